fir_frame_collector: RTL
========================

Name: fir_frame_collector

Overview:
- Consumer-side partner of the FIR stage. Takes the FIR output stream (a fir_valid level plus a 16-bit fir_d sample on every valid cycle) and packs consecutive samples into fixed-length frames for the downstream block-processing stage (FFT/analysis).
- Ping-pong buffered: one bank fills while the other is presented on a valid/ready frame interface.

Parameters:
- DATA_W, 16: sample width; matches fir_d.
- FRAME_LEN, 16: samples per frame; power of two, 4..64.
- DROP_CNT_W, 8: width of the dropped-sample counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- fir_valid  in  1  high = fir_d carries one sample this cycle.
- fir_d  in  DATA_W  signed FIR output sample.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_ready  in  1  downstream accepts; transfer happens when frame_valid & frame_ready.
- frame_data  out  FRAME_LEN*DATA_W  slice [i*DATA_W +: DATA_W] = i-th sample of the frame, i=0 oldest.
- frame_last  out  1  frame is a zero-padded end-of-stream frame; only meaningful with the optional feature.
- overflow  out  1  sticky; set when any sample is dropped.
- drop_cnt  out  DROP_CNT_W  saturating count of dropped samples.

Behaviour:
- Reset (rst=0, async): all outputs 0, frame_data 0; both banks empty; wr_cnt=0; wr_bank=0; write FSM in FILL.
- Bank pointer: wr_bank selects the filling bank; the read bank is ~wr_bank. A swap flips wr_bank and clears wr_cnt.
- Write FSM FILL:
  - fir_valid=1: store fir_d at index wr_cnt of the write bank, then wr_cnt+1.
  - When the sample at index FRAME_LEN-1 is stored at edge t:
    - Read side empty, or handshake completing in the same cycle: swap at t. frame_valid=1 with the new frame from cycle t+1.
    - Otherwise: go to HOLD.
- Write FSM HOLD (write bank full, read bank occupied):
  - Every fir_valid=1 cycle drops its sample: overflow<=1, drop_cnt+1, saturating at all-ones.
  - When the handshake completes: swap at that edge, go to FILL with wr_cnt=0, frame_valid stays 1 with the new frame next cycle.
  - The sample arriving in the swap cycle is also dropped.
- Read side:
  - frame_valid rises only on a swap. It falls on the handshake edge unless a swap occurs at that same edge.
  - frame_data is stable while frame_valid=1 and frame_ready=0.
- Latency: frame_valid rises one cycle after the edge capturing the last sample (no-backpressure case).
- Throughput: back-to-back frames sustained with frame_ready held 1; no sample is ever dropped in that case.
- End of stream (fir_valid falls, 1->0, tracked by a 1-cycle delayed copy) while in FILL with wr_cnt>0: see Optional Feature. With wr_cnt=0, nothing happens.
- Reset asserted mid-frame discards both banks with no partial output. overflow and drop_cnt clear only on reset.

Optional Feature:
- Macro: FIR_FRAME_FLUSH_EN.
- Defined: on the end-of-stream edge with wr_cnt>0, entries wr_cnt..FRAME_LEN-1 read as 0 and the frame is treated as complete (swap or HOLD exactly as a full frame). That frame is presented with frame_last=1. A new sample in the cycle after the fall starts a fresh frame only after the swap; in HOLD it is dropped as usual.
- Undefined: the partial frame is discarded, wr_cnt<=0 at the cycle after the fall, and frame_last is tied 0.

Decomposition:
- Shared package fir_pkg holds FIR_DATA_W=16, FIR_FRAME_LEN_DEF=16, and the write-FSM state enum {FILL, HOLD}. It is shared with the FIR stage and later consumers.
- One natural sub-module: fir_frame_bank. It is a single FRAME_LEN x DATA_W register bank with indexed write, a zero-fill-from-index clear (used for flush), and a flat read bus. It is instantiated twice.
- Top level holds the FSM, pointer, counters and handshake.

Test Plan:
- Reset, then 16 samples 1..16 with frame_ready=1 -> frame_valid high exactly 1 cycle after the 16th sample edge, slice0=1 … slice15=16, high for one cycle, overflow=0.
- 48 continuous samples 0..47 with frame_ready=1 -> three frames [0..15], [16..31], [32..47], no gaps, drop_cnt=0.
- frame_ready=0 for 40 samples of stream 0..39 -> frame0=[0..15] held stable, bank2=[16..31] full, samples 32..39 dropped, drop_cnt=8, overflow=1. Raise frame_ready -> frame0 then [16..31] delivered.
- Sustained backpressure with 300 dropped samples -> drop_cnt saturates at 255, overflow stays 1 until rst=0.
- With FIR_FRAME_FLUSH_EN: 5 samples -7,-6,-5,-4,-3, then fir_valid low -> frame slices 0..4 = -7..-3, slices 5..15 = 0, frame_last=1. Without the macro: no frame, and the next 16 samples form a clean frame.
- rst pulsed low asynchronously mid-frame (wr_cnt=9) while frame_valid=1 -> all outputs 0 immediately. The next 16 samples produce a frame containing only post-reset data.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR-chain definitions: default widths and the frame-collector write FSM states.
package fir_pkg;

  localparam int unsigned FIR_DATA_W        = 16;
  localparam int unsigned FIR_FRAME_LEN_DEF = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } wr_state_t;

endpackage

// File: rtl/fir_frame_bank.sv
// One FRAME_LEN x DATA_W sample bank: indexed write, zero-fill from an index upward, flat read bus.
module fir_frame_bank #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]             wr_d,
  input  logic                          clr,
  input  logic [IDX_W-1:0]              clr_idx,
  output logic [FRAME_LEN*DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [FRAME_LEN];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FRAME_LEN; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
        if (we && (wr_idx == IDX_W'(i))) mem[i] <= wr_d;
        else if (clr && (IDX_W'(i) >= clr_idx)) mem[i] <= '0;
      end
    end
  end

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_rd
    assign rd_data[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/fir_frame_collector.sv
// Packs the FIR sample stream into ping-pong buffered frames on a valid/ready interface.
// Optional end-of-stream zero-padded flush: define FIR_FRAME_FLUSH_EN.
module fir_frame_collector
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W     = FIR_DATA_W,
  parameter int unsigned FRAME_LEN  = FIR_FRAME_LEN_DEF,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fir_valid,
  input  logic [DATA_W-1:0]             fir_d,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [FRAME_LEN*DATA_W-1:0]   frame_data,
  output logic                          frame_last,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  wr_state_t state, state_next;

  logic               wr_bank;
  logic [IDX_W-1:0]   wr_cnt;
  logic               valid_d;
  logic               hs, rd_free;
  logic               full_evt, eos, flush, discard, complete;
  logic               store, swap, drop;
  logic [FRAME_LEN*DATA_W-1:0] rd0, rd1;

  assign hs       = frame_valid & frame_ready;
  assign rd_free  = ~frame_valid | frame_ready;
  assign full_evt = (state == FILL) & fir_valid & (wr_cnt == LAST_IDX);
  assign eos      = (state == FILL) & valid_d & ~fir_valid & (wr_cnt != '0);

`ifdef FIR_FRAME_FLUSH_EN
  assign flush   = eos;
  assign discard = 1'b0;
`else
  assign flush   = 1'b0;
  assign discard = eos;
`endif

  assign complete = full_evt | flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (complete && !rd_free) state_next = HOLD;
      HOLD:    if (hs) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    store = 1'b0;
    swap  = 1'b0;
    drop  = 1'b0;
    unique case (state)
      FILL: begin
        store = fir_valid;
        swap  = complete & rd_free;
      end
      HOLD: begin
        drop = fir_valid;
        swap = hs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      valid_d     <= 1'b0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      valid_d <= fir_valid;
      if (swap) wr_bank <= ~wr_bank;
      if (swap || complete || discard) wr_cnt <= '0;
      else if (store)                  wr_cnt <= wr_cnt + 1'b1;
      if (swap)    frame_valid <= 1'b1;
      else if (hs) frame_valid <= 1'b0;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef FIR_FRAME_FLUSH_EN
  // A flushed frame parked in HOLD carries its last flag until it is swapped to the read side.
  logic pend_last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_last <= 1'b0;
      pend_last  <= 1'b0;
    end else if (swap) begin
      frame_last <= (state == FILL) ? flush : pend_last;
      pend_last  <= 1'b0;
    end else begin
      if (hs)    frame_last <= 1'b0;
      if (flush) pend_last  <= 1'b1;
    end
  end
`else
  assign frame_last = 1'b0;
`endif

  fir_frame_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (store & ~wr_bank),
    .wr_idx  (wr_cnt),
    .wr_d    (fir_d),
    .clr     (flush & ~wr_bank),
    .clr_idx (wr_cnt),
    .rd_data (rd0)
  );

  fir_frame_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (store & wr_bank),
    .wr_idx  (wr_cnt),
    .wr_d    (fir_d),
    .clr     (flush & wr_bank),
    .clr_idx (wr_cnt),
    .rd_data (rd1)
  );

  assign frame_data = wr_bank ? rd0 : rd1;

endmodule
